vga_timing: RTL and testbench

Pixel timing generator for the 640x480@60 Hz VGA path, clocked by the 25 MHz pixel clock. It scans a horizontal/vertical counter pair and produces the synchronous-ROM read address for a tiled, integer-scaled sprite image. It also produces HSYNC, VSYNC and data-active outputs, delayed to line up with the ROM read data. It sits directly upstream of the sprite ROM and the colour/gray pixel path, which consume its address and qualifiers.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_sync_delay.sv | 38 +++
 rtl/vga_timing.sv | 123 ++++++++++++
 tb/tb_vga_timing.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, counter width and
// the qualifier bundle shared by the VGA timing generator.
package vga_timing_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF =
        H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF =
        V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int CNT_W = clog2(
        (H_TOTAL_DEF > V_TOTAL_DEF) ? H_TOTAL_DEF : V_TOTAL_DEF);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic da;
        logic fs;
    } qual_t;

endpackage

// File: rtl/vga_timing_sync_delay.sv
// sync_delay: N-stage, W-bit shift register with an
// asynchronous active-low reset to a configurable value.
module sync_delay #(
    parameter int         N       = 1,
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[N-1];

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480 scan counters, tiled sprite ROM address and
// sync/active qualifiers delayed to match the ROM read latency.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE  = H_VISIBLE_DEF,
    parameter int   H_FRONT    = H_FRONT_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BACK     = H_BACK_DEF,
    parameter int   V_VISIBLE  = V_VISIBLE_DEF,
    parameter int   V_FRONT    = V_FRONT_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BACK     = V_BACK_DEF,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   IMG_W_LOG2 = 4,
    parameter int   IMG_H_LOG2 = 5,
    parameter int   SCALE_LOG2 = 2,
    parameter int   PIPE_DLY   = 1
) (
    input  logic                             VGA_CLK,
    input  logic                             RESET_N,
    input  logic                             pix_en,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] vaddr,
    output logic [CNT_W-1:0]                 hcount,
    output logic [CNT_W-1:0]                 vcount,
    output logic                             VGA_HS,
    output logic                             VGA_VS,
    output logic                             vga_DA,
    output logic                             frame_start
);

    localparam int AW = IMG_W_LOG2 + IMG_H_LOG2;

    localparam cnt_t H_LAST =
        cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_LAST =
        cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_BEG = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t VS_BEG = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam qual_t QUAL_RST = '{
        hs: ~SYNC_POL,
        vs: ~SYNC_POL,
        da: 1'b0,
        fs: 1'b0
    };

    cnt_t          h_q, h_d;
    cnt_t          v_q, v_d;
    logic [AW-1:0] vaddr_q, vaddr_d;
    qual_t         qual_now;
    qual_t         qual_dly;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
            end else begin
                h_d = h_q + cnt_t'(1);
            end
        end
    end

    // Built from the next counter value so address and counters
    // register on the same edge.
    always_comb begin
        vaddr_d = '0;
        if (h_d < H_VIS && v_d < V_VIS) begin
            vaddr_d = {
                v_d[SCALE_LOG2+IMG_H_LOG2-1 -: IMG_H_LOG2],
                h_d[SCALE_LOG2+IMG_W_LOG2-1 -: IMG_W_LOG2]
            };
        end
    end

    always_comb begin
        qual_now.hs = (h_q >= HS_BEG && h_q < HS_END)
                    ? SYNC_POL : ~SYNC_POL;
        qual_now.vs = (v_q >= VS_BEG && v_q < VS_END)
                    ? SYNC_POL : ~SYNC_POL;
        qual_now.da = (h_q < H_VIS) && (v_q < V_VIS);
        qual_now.fs = pix_en && (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_q     <= '0;
            v_q     <= '0;
            vaddr_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            vaddr_q <= vaddr_d;
        end
    end

    sync_delay #(
        .N       (PIPE_DLY),
        .W       ($bits(qual_t)),
        .RST_VAL (QUAL_RST)
    ) u_qual_dly (
        .clk   (VGA_CLK),
        .rst_n (RESET_N),
        .din   (qual_now),
        .dout  (qual_dly)
    );

    assign vaddr       = vaddr_q;
    assign hcount      = h_q;
    assign vcount      = v_q;
    assign VGA_HS      = qual_dly.hs;
    assign VGA_VS      = qual_dly.vs;
    assign vga_DA      = qual_dly.da;
    assign frame_start = qual_dly.fs;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: default 640x480 instance plus a shrunken instance
// so frame-level behaviour fits a short run; arithmetic reference model.
module tb_vga_timing;

    localparam int NI = 2;
    localparam int P_HV  [NI] = '{640, 20};
    localparam int P_HF  [NI] = '{16, 2};
    localparam int P_HSY [NI] = '{96, 4};
    localparam int P_HB  [NI] = '{48, 3};
    localparam int P_VV  [NI] = '{480, 12};
    localparam int P_VF  [NI] = '{10, 2};
    localparam int P_VSY [NI] = '{2, 2};
    localparam int P_VB  [NI] = '{33, 3};
    localparam bit P_POL [NI] = '{1'b0, 1'b1};
    localparam int P_IW  [NI] = '{4, 3};
    localparam int P_IH  [NI] = '{5, 2};
    localparam int P_SC  [NI] = '{2, 1};
    localparam int P_D   [NI] = '{1, 3};
    localparam int MASK = 16'hFFFF;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic [8:0] va0;
    logic [4:0] va1;
    logic [9:0] hc0, vc0, hc1, vc1;
    logic       hs0, vs0, da0, fs0;
    logic       hs1, vs1, da1, fs1;

    always #20 clk = ~clk;

    vga_timing u_dut (
        .VGA_CLK     (clk),
        .RESET_N     (rst_n),
        .pix_en      (pix_en),
        .vaddr       (va0),
        .hcount      (hc0),
        .vcount      (vc0),
        .VGA_HS      (hs0),
        .VGA_VS      (vs0),
        .vga_DA      (da0),
        .frame_start (fs0)
    );

    vga_timing #(
        .H_VISIBLE  (P_HV[1]),
        .H_FRONT    (P_HF[1]),
        .H_SYNC     (P_HSY[1]),
        .H_BACK     (P_HB[1]),
        .V_VISIBLE  (P_VV[1]),
        .V_FRONT    (P_VF[1]),
        .V_SYNC     (P_VSY[1]),
        .V_BACK     (P_VB[1]),
        .SYNC_POL   (P_POL[1]),
        .IMG_W_LOG2 (P_IW[1]),
        .IMG_H_LOG2 (P_IH[1]),
        .SCALE_LOG2 (P_SC[1]),
        .PIPE_DLY   (P_D[1])
    ) u_small (
        .VGA_CLK     (clk),
        .RESET_N     (rst_n),
        .pix_en      (pix_en),
        .vaddr       (va1),
        .hcount      (hc1),
        .vcount      (vc1),
        .VGA_HS      (hs1),
        .VGA_VS      (vs1),
        .vga_DA      (da1),
        .frame_start (fs1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e = 0;
    int n [NI];
    logic [3:0] rec [NI][65536];

    bit stats_on = 1'b0;
    int h0_cyc, hs_run, da_run, vs_run;
    int last_fall, last_fs;
    logic prev_hs0, prev_da0, prev_vs1;

    int pts [4][3] = '{
        '{4, 0, 1}, '{0, 4, 16}, '{64, 0, 0}, '{700, 10, 0}
    };

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ht(input int i);
        return P_HV[i] + P_HF[i] + P_HSY[i] + P_HB[i];
    endfunction

    function automatic int vt(input int i);
        return P_VV[i] + P_VF[i] + P_VSY[i] + P_VB[i];
    endfunction

    function automatic logic [3:0] qual(input int i, input int cnt,
                                        input bit en);
        int h, v;
        logic hs, vs, da, fs;
        h = cnt % ht(i);
        v = (cnt / ht(i)) % vt(i);
        hs = (h >= P_HV[i] + P_HF[i] && h < P_HV[i] + P_HF[i] + P_HSY[i])
           ? P_POL[i] : !P_POL[i];
        vs = (v >= P_VV[i] + P_VF[i] && v < P_VV[i] + P_VF[i] + P_VSY[i])
           ? P_POL[i] : !P_POL[i];
        da = (h < P_HV[i]) && (v < P_VV[i]);
        fs = (h == 0) && (v == 0) && en;
        return {hs, vs, da, fs};
    endfunction

    function automatic int exp_vaddr(input int i, input int cnt);
        int h, v;
        h = cnt % ht(i);
        v = (cnt / ht(i)) % vt(i);
        if (h >= P_HV[i] || v >= P_VV[i]) return 0;
        return ((v >> P_SC[i]) % (1 << P_IH[i])) * (1 << P_IW[i])
             + ((h >> P_SC[i]) % (1 << P_IW[i]));
    endfunction

    function automatic logic [3:0] rst_q(input int i);
        return {!P_POL[i], !P_POL[i], 1'b0, 1'b0};
    endfunction

    function automatic logic [31:0] o_hc(input int i);
        return (i == 0) ? 32'(hc0) : 32'(hc1);
    endfunction

    function automatic logic [31:0] o_vc(input int i);
        return (i == 0) ? 32'(vc0) : 32'(vc1);
    endfunction

    function automatic logic [31:0] o_va(input int i);
        return (i == 0) ? 32'(va0) : 32'(va1);
    endfunction

    function automatic logic [31:0] o_q(input int i);
        return (i == 0) ? 32'({hs0, vs0, da0, fs0})
                        : 32'({hs1, vs1, da1, fs1});
    endfunction

    task automatic check_model();
        logic [3:0] eq;
        int h, v;
        for (int i = 0; i < NI; i++) begin
            h = n[i] % ht(i);
            v = (n[i] / ht(i)) % vt(i);
            eq = (e >= P_D[i]) ? rec[i][(e - P_D[i] + 1) & MASK]
                               : rst_q(i);
            chk($sformatf("hcount%0d", i), o_hc(i), h);
            chk($sformatf("vcount%0d", i), o_vc(i), v);
            chk($sformatf("vaddr%0d", i), o_va(i), exp_vaddr(i, n[i]));
            chk($sformatf("qual%0d", i), o_q(i), 32'(eq));
        end
        h = n[0] % ht(0);
        v = (n[0] / ht(0)) % vt(0);
        for (int k = 0; k < 4; k++) begin
            if (h == pts[k][0] && v == pts[k][1]) begin
                chk($sformatf("addr_map_h%0d_v%0d", h, v),
                    32'(va0), pts[k][2]);
            end
        end
    endtask

    task automatic stats_reset();
        h0_cyc = 0;
        hs_run = 0;
        da_run = 0;
        vs_run = 0;
        last_fall = -1;
        last_fs = -1;
        prev_hs0 = !P_POL[0];
        prev_da0 = 1'b0;
        prev_vs1 = !P_POL[1];
    endtask

    task automatic stats();
        if (!stats_on) return;
        if (hc0 == 10'd0) h0_cyc = cyc;
        if (hs0 === 1'b0) hs_run++;
        if (prev_hs0 === 1'b1 && hs0 === 1'b0) begin
            chk("hs_fall_offset", cyc - h0_cyc,
                P_HV[0] + P_HF[0] + P_D[0]);
            if (last_fall >= 0) chk("line_period", cyc - last_fall, ht(0));
            last_fall = cyc;
        end
        if (prev_hs0 === 1'b0 && hs0 === 1'b1) begin
            chk("hs_width", hs_run, P_HSY[0]);
            hs_run = 0;
        end
        if (da0 === 1'b1) da_run++;
        if (prev_da0 === 1'b1 && da0 === 1'b0) begin
            chk("da_width", da_run, P_HV[0]);
            da_run = 0;
        end
        if (vs1 === P_POL[1]) vs_run++;
        if (prev_vs1 === P_POL[1] && vs1 === !P_POL[1]) begin
            chk("vs_width", vs_run, P_VSY[1] * ht(1));
            vs_run = 0;
        end
        if (fs1 === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", cyc - last_fs, ht(1) * vt(1));
            last_fs = cyc;
        end
        prev_hs0 = hs0;
        prev_da0 = da0;
        prev_vs1 = vs1;
    endtask

    task automatic cycle(input bit en);
        check_model();
        stats();
        pix_en = en;
        for (int i = 0; i < NI; i++) begin
            rec[i][(e + 1) & MASK] = qual(i, n[i], en);
        end
        @(posedge clk);
        e++;
        cyc++;
        if (en) begin
            for (int i = 0; i < NI; i++) n[i]++;
        end
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hs0", 32'(hs0), 1);
        chk("rst_vs0", 32'(vs0), 1);
        chk("rst_da0", 32'(da0), 0);
        chk("rst_va0", 32'(va0), 0);
        chk("rst_hc0", 32'(hc0), 0);
        chk("rst_vc0", 32'(vc0), 0);
        chk("rst_hs1", 32'(hs1), 0);
        chk("rst_vs1", 32'(vs1), 0);
        chk("rst_fs1", 32'(fs1), 0);
        n[0] = 0;
        n[1] = 0;
        e = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        int t0;
        logic [8:0] va_hold;

        rst_n = 1'b0;
        pix_en = 1'b0;
        n[0] = 0;
        n[1] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) cycle(1'b1);

        async_reset();
        cycle(1'b1);
        chk("hcount_after_release", 32'(hc0), 1);

        async_reset();
        stats_reset();
        stats_on = 1'b1;
        repeat (11000) cycle(1'b1);
        stats_on = 1'b0;

        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (hc0 == 10'd0) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1);
        end
        chk("reach_line_start", 32'(found), 1);
        t0 = cyc;
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (hc0 == 10'd100) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1);
        end
        chk("reach_h100", 32'(found), 1);
        va_hold = va0;
        repeat (37) begin
            cycle(1'b0);
            chk("hold_hcount", 32'(hc0), 100);
            chk("hold_vaddr", 32'(va0), 32'(va_hold));
            chk("hold_da", 32'(da0), 1);
        end
        cycle(1'b1);
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (hc0 == 10'd0) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1);
        end
        chk("reach_next_line", 32'(found), 1);
        chk("gated_line_len", cyc - t0, ht(0) + 37);

        repeat (20000) cycle($urandom_range(7, 0) != 0);

        found = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (vc1 == 10'd14 && hc1 == 10'd5) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1);
        end
        chk("reach_small_vsync", 32'(found), 1);
        chk("small_vs_active", 32'(vs1), 32'(P_POL[1]));
        async_reset();
        found = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1);
            if (fs1 === 1'b1) begin
                found = 1'b1;
                chk("fs_after_release", k, P_D[1]);
                break;
            end
        end
        chk("fs_seen_after_reset", 32'(found), 1);

        repeat (1500) cycle($urandom_range(3, 0) != 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
